johnson_phase_monitor: RTL and testbench
========================================

# johnson_phase_monitor

Downstream consumer of the WIDTH-bit Johnson counter. Samples the counter's code every `code_valid` cycle and decodes it into a phase index and a one-hot phase vector. Checks that each sample is a legal Johnson code and the exact successor of the previous one. Counts full revolutions and step errors, exposing a `locked` status for the sequencing logic that uses the phases.

## Interface
- WIDTH, 4, Johnson code width; 2*WIDTH legal phases
- REV_W, 8, width of revolution counter
- ERR_W, 4, width of saturating error counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- code_in  in  WIDTH  Johnson code from the counter
- code_valid  in  1  sample code_in this cycle
- phase_idx  out  $clog2(2*WIDTH)  decoded phase of last legal sample
- phase_onehot  out  2*WIDTH  bit phase_idx set; all-zero when not locked
- locked  out  1  sequence tracking established
- illegal  out  1  one-cycle pulse: sampled code not a legal Johnson code
- step_err  out  1  one-cycle pulse: legal code but not the successor while LOCKED
- rev_pulse  out  1  one-cycle pulse on phase 2W-1 -> 0 while LOCKED
- rev_count  out  REV_W  revolutions since reset, wraps
- err_count  out  ERR_W  illegal + step_err events, saturates at all-ones

## Operation
- Legal codes, phase k:
  - For k in 0..WIDTH: the top k bits are 1 and the rest are 0.
  - For k in WIDTH+1..2W-1: the top k-WIDTH bits are 0 and the rest are 1.
  - WIDTH=4 sequence: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
  - Successor of k is (k+1) mod 2W.
  - Every other code is illegal (e.g. 1011, 0101).
- States are IDLE, ACQ and LOCKED. Only cycles with code_valid=1 are evaluated; code_valid=0 holds all state and counters, and the pulses are 0.
- IDLE:
  - Legal code -> ACQ; phase_idx is loaded.
  - Illegal code -> stay in IDLE; illegal pulses.
- ACQ:
  - Successor of phase_idx -> LOCKED; phase_idx is updated.
  - Any other legal code -> stay in ACQ; phase_idx is reloaded; no error.
  - Illegal code -> IDLE; illegal pulses.
- LOCKED:
  - Successor -> stay in LOCKED; phase_idx is updated.
  - If the successor step was 2W-1 -> 0: rev_pulse=1 and rev_count increments mod 2^REV_W.
  - Legal non-successor, including a repeated code -> ACQ; phase_idx is loaded with the new phase; step_err pulses.
  - Illegal code -> IDLE; illegal pulses.
- err_count increments by one on each illegal or step_err pulse and saturates.
- illegal and step_err are never both 1.
- phase_onehot = locked ? (1 << phase_idx) : 0.

## Timing
- All outputs are registered. A sample taken at edge N shows its effect after edge N+1, i.e. one cycle of latency.
- The pulses last exactly one cycle. Back-to-back valid samples may pulse in consecutive cycles.
- Reset values: state IDLE; phase_idx 0; phase_onehot 0; locked 0; illegal 0; step_err 0; rev_pulse 0; rev_count 0; err_count 0.
- Reset takes priority over code_valid in the same cycle. Asserting reset mid-sequence returns every output to its reset value on the next edge.
- rev_count wraps at 2^REV_W - 1 -> 0 with no flag. err_count holds at 2^ERR_W - 1.
- The minimum time from the first legal sample to locked=1 is two valid samples plus one cycle.

## Structure
- Shared package `johnson_pkg`:
  - state enum (IDLE, ACQ, LOCKED)
  - the PHASES = 2*WIDTH constant
  - function `johnson_succ(idx)`
- Sub-module `johnson_code_decoder`, purely combinational:
  - input: code
  - outputs: legal, idx
  - implementation: compares the code against the 2*WIDTH generated legal patterns
- Top level: FSM, phase register, counters and output registers.

## Test plan
- Reset, then 0000, 1000, 1100, …, 0001, 0000 at valid every cycle. Required:
  - locked=1 after the second sample
  - phase_onehot walks 00000001 -> 10000000
  - one rev_pulse on the 0001->0000 step
  - rev_count=1, err_count=0
- Feed 1011 first, then the legal sequence from 0000. Required:
  - illegal pulses once; state stays IDLE
  - then normal lock
  - err_count=1
- While LOCKED at 1110, feed 1110 again. Required:
  - step_err=1 for one cycle; locked=0
  - state ACQ with phase_idx=3
  - next sample 1111 relocks
- code_valid toggled 1/0 through a full revolution. Required:
  - identical phase and rev results to the first scenario
  - no pulses in code_valid=0 cycles
- Reset asserted for one cycle mid-revolution with code_valid=1 held. Required:
  - all outputs at reset values the next cycle
  - relock after two legal samples
- 20 consecutive illegal samples (0101). Required:
  - err_count saturates at 15
  - illegal pulses every cycle; locked=0

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter phase monitor.
package johnson_pkg;

  localparam int WIDTH  = 4;
  localparam int PHASES = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  // Next phase in a ring of 'phases' legal codes.
  function automatic int johnson_succ(input int idx, input int phases = PHASES);
    return (idx >= phases - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/johnson_phase_monitor_if.sv
// Bundle between the Johnson counter side and the phase monitor.
interface johnson_phase_monitor_if #(
  parameter int WIDTH = 4,
  parameter int REV_W = 8,
  parameter int ERR_W = 4
);
  localparam int PHASES = 2 * WIDTH;
  localparam int IDX_W  = $clog2(PHASES);

  logic [WIDTH-1:0]  code_in;
  logic              code_valid;
  logic [IDX_W-1:0]  phase_idx;
  logic [PHASES-1:0] phase_onehot;
  logic              locked;
  logic              illegal;
  logic              step_err;
  logic              rev_pulse;
  logic [REV_W-1:0]  rev_count;
  logic [ERR_W-1:0]  err_count;

  modport master (
    output code_in, code_valid,
    input  phase_idx, phase_onehot, locked, illegal, step_err,
    input  rev_pulse, rev_count, err_count
  );

  modport slave (
    input  code_in, code_valid,
    output phase_idx, phase_onehot, locked, illegal, step_err,
    output rev_pulse, rev_count, err_count
  );

endinterface

// File: rtl/johnson_code_decoder.sv
// Combinational decoder: matches a code against every legal Johnson pattern.
module johnson_code_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH = johnson_pkg::WIDTH,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_idx
);

  // Phases 0..WIDTH fill ones from the top; later phases fill zeros from the top.
  function automatic logic [WIDTH-1:0] phaseCode(input int k);
    logic [WIDTH-1:0] c;
    for (int b = 0; b < WIDTH; b++) begin
      if (k <= WIDTH) c[b] = (b >= WIDTH - k);
      else            c[b] = !(b >= WIDTH - (k - WIDTH));
    end
    return c;
  endfunction

  always_comb begin
    o_legal = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      if (i_code == phaseCode(k)) begin
        o_legal = 1'b1;
        o_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Tracks a Johnson counter: decodes phase, checks succession, counts revolutions and errors.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH = johnson_pkg::WIDTH,
  parameter int REV_W = 8,
  parameter int ERR_W = 4
) (
  input logic clk,
  input logic reset,
  johnson_phase_monitor_if.slave bus
);

  localparam int PHASES_L = 2 * WIDTH;
  localparam int IDX_W    = $clog2(PHASES_L);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [PHASES_L-1:0] r_onehot;
  logic                r_locked;
  logic                r_illegal;
  logic                r_stepErr;
  logic                r_revPulse;
  logic [REV_W-1:0]    r_revCount;
  logic [ERR_W-1:0]    r_errCount;

  logic                w_legal;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_succ;
  logic                w_isSucc;
  logic                w_wrap;
  logic                w_errFull;
  logic [PHASES_L-1:0] w_onehot;

  johnson_code_decoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decoder (
    .i_code  (bus.code_in),
    .o_legal (w_legal),
    .o_idx   (w_idx)
  );

  assign w_succ    = IDX_W'(johnson_succ(int'(r_idx), PHASES_L));
  assign w_isSucc  = (w_idx == w_succ);
  assign w_wrap    = (r_idx == IDX_W'(PHASES_L - 1));
  assign w_errFull = &r_errCount;

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
  end

  // An illegal code always drops back to IDLE regardless of the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_onehot   <= '0;
      r_locked   <= 1'b0;
      r_illegal  <= 1'b0;
      r_stepErr  <= 1'b0;
      r_revPulse <= 1'b0;
      r_revCount <= '0;
      r_errCount <= '0;
    end else begin
      r_illegal  <= 1'b0;
      r_stepErr  <= 1'b0;
      r_revPulse <= 1'b0;
      if (bus.code_valid) begin
        if (!w_legal) begin
          r_state   <= IDLE;
          r_locked  <= 1'b0;
          r_onehot  <= '0;
          r_illegal <= 1'b1;
          if (!w_errFull) r_errCount <= r_errCount + ERR_W'(1);
        end else begin
          case (r_state)
            IDLE: begin
              r_state <= ACQ;
              r_idx   <= w_idx;
            end
            ACQ: begin
              r_idx <= w_idx;
              if (w_isSucc) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_onehot <= w_onehot;
              end
            end
            LOCKED: begin
              r_idx <= w_idx;
              if (w_isSucc) begin
                r_onehot <= w_onehot;
                if (w_wrap) begin
                  r_revPulse <= 1'b1;
                  r_revCount <= r_revCount + REV_W'(1);
                end
              end else begin
                r_state   <= ACQ;
                r_locked  <= 1'b0;
                r_onehot  <= '0;
                r_stepErr <= 1'b1;
                if (!w_errFull) r_errCount <= r_errCount + ERR_W'(1);
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.phase_idx    = r_idx;
  assign bus.phase_onehot = r_onehot;
  assign bus.locked       = r_locked;
  assign bus.illegal      = r_illegal;
  assign bus.step_err     = r_stepErr;
  assign bus.rev_pulse    = r_revPulse;
  assign bus.rev_count    = r_revCount;
  assign bus.err_count    = r_errCount;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed and random checks of the phase monitor against a sequence-level reference model.
module tb_johnson_phase_monitor;

  localparam int W  = 4;
  localparam int P  = 2 * W;
  localparam int RW = 8;
  localparam int EW = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  johnson_phase_monitor_if #(.WIDTH(W), .REV_W(RW), .ERR_W(EW)) bus ();

  johnson_phase_monitor #(.WIDTH(W), .REV_W(RW), .ERR_W(EW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracking mode 0=searching, 1=acquiring, 2=tracking
  int codes [P];
  int mMode, mIdx, mRev, mErr;
  bit mIllegal, mStep, mRevPulse;

  function automatic int phaseOf(input int code);
    for (int k = 0; k < P; k++) if (codes[k] == code) return k;
    return -1;
  endfunction

  task automatic modelStep(input bit valid, input int code, input bit rst);
    int p;
    mIllegal = 0; mStep = 0; mRevPulse = 0;
    if (rst) begin
      mMode = 0; mIdx = 0; mRev = 0; mErr = 0;
    end else if (valid) begin
      p = phaseOf(code);
      if (p < 0) begin
        mIllegal = 1; mMode = 0;
        if (mErr < (1 << EW) - 1) mErr++;
      end else if (mMode == 0) begin
        mMode = 1; mIdx = p;
      end else if (p == (mIdx + 1) % P) begin
        if (mMode == 2 && p == 0) begin
          mRevPulse = 1; mRev = (mRev + 1) % (1 << RW);
        end
        mMode = 2; mIdx = p;
      end else begin
        if (mMode == 2) begin
          mStep = 1;
          if (mErr < (1 << EW) - 1) mErr++;
        end
        mMode = 1; mIdx = p;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] expHot;
    expHot = (mMode == 2) ? (32'd1 << mIdx) : 32'd0;
    check("phase_idx", 32'(bus.phase_idx), 32'(mIdx));
    check("phase_onehot", 32'(bus.phase_onehot), expHot);
    check("locked", 32'(bus.locked), 32'(mMode == 2));
    check("illegal", 32'(bus.illegal), 32'(mIllegal));
    check("step_err", 32'(bus.step_err), 32'(mStep));
    check("rev_pulse", 32'(bus.rev_pulse), 32'(mRevPulse));
    check("rev_count", 32'(bus.rev_count), 32'(mRev));
    check("err_count", 32'(bus.err_count), 32'(mErr));
  endtask

  task automatic applyStimulus(input bit valid, input int code, input bit rst);
    @(negedge clk);
    reset          = rst;
    bus.code_valid = valid;
    bus.code_in    = W'(code);
    @(posedge clk);
    modelStep(valid, code, rst);
    #1;
    checkOutput();
  endtask

  task automatic revolution(input bool_toggle);
  endtask

  initial begin
    int g;
    checks = 0; errors = 0;
    for (int k = 0; k < P; k++)
      codes[k] = (k <= W) ? (((1 << k) - 1) << (W - k)) : ((1 << (P - k)) - 1);
    reset = 1'b1; bus.code_valid = 1'b0; bus.code_in = '0;
    mMode = 0; mIdx = 0; mRev = 0; mErr = 0;

    $display("[TB] reset and clean revolution");
    applyStimulus(1, 0, 1);
    check("reset_locked", 32'(bus.locked), 32'd0);
    for (int k = 0; k <= P; k++) applyStimulus(1, codes[k % P], 0);
    check("rev1_count", 32'(bus.rev_count), 32'd1);
    check("rev1_err", 32'(bus.err_count), 32'd0);

    $display("[TB] illegal first sample then lock");
    applyStimulus(1, 0, 1);
    applyStimulus(1, 4'b1011, 0);
    check("ill_pulse", 32'(bus.illegal), 32'd1);
    for (int k = 0; k <= P; k++) applyStimulus(1, codes[k % P], 0);
    check("ill_err", 32'(bus.err_count), 32'd1);

    $display("[TB] repeated code while locked");
    applyStimulus(1, 0, 1);
    for (int k = 0; k <= 3; k++) applyStimulus(1, codes[k], 0);
    applyStimulus(1, 4'b1110, 0);
    check("rep_step", 32'(bus.step_err), 32'd1);
    check("rep_idx", 32'(bus.phase_idx), 32'd3);
    applyStimulus(1, 4'b1111, 0);
    check("rep_relock", 32'(bus.locked), 32'd1);

    $display("[TB] toggled valid revolution");
    applyStimulus(1, 0, 1);
    for (int k = 0; k <= P; k++) begin
      applyStimulus(1, codes[k % P], 0);
      applyStimulus(0, $urandom_range(0, 15), 0);
    end
    check("tog_count", 32'(bus.rev_count), 32'd1);

    $display("[TB] reset mid revolution");
    for (int k = 1; k <= 3; k++) applyStimulus(1, codes[k], 0);
    applyStimulus(1, codes[4], 1);
    check("mid_locked", 32'(bus.locked), 32'd0);
    applyStimulus(1, codes[5], 0);
    applyStimulus(1, codes[6], 0);
    check("mid_relock", 32'(bus.locked), 32'd1);

    $display("[TB] illegal saturation");
    for (int n = 0; n < 20; n++) applyStimulus(1, 4'b0101, 0);
    check("sat_err", 32'(bus.err_count), 32'd15);

    $display("[TB] random stream");
    applyStimulus(1, 0, 1);
    g = 0;
    for (int n = 0; n < 400; n++) begin
      int r, code;
      r = $urandom_range(0, 19);
      if (r == 0)      code = $urandom_range(0, 15);
      else if (r == 1) code = codes[g];
      else begin
        g = (g + 1) % P; code = codes[g];
      end
      applyStimulus($urandom_range(0, 3) != 0, code, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
